// File: rtl/plot_receiver_pkg.sv
// Shared types and constants for the plot receiver: screen geometry defaults,
// bus widths, FSM state encoding and the pixel address helper.
package plot_receiver_pkg;

    localparam int DEF_SCREEN_W = 320;
    localparam int DEF_SCREEN_H = 240;
    localparam int X_W          = 9;
    localparam int Y_W          = 8;
    localparam int COLOUR_W     = 12;
    localparam int ADDR_W       = 17;
    localparam int CLIP_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RD_ADDR = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_e;

    // One buffered pixel write: framebuffer address plus colour (29 bits).
    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [COLOUR_W-1:0] colour;
    } entry_t;

    // Linear framebuffer address for a 320-wide screen: y*320 + x written as
    // y*256 + y*64 + x so no multiplier is needed. Full 17-bit result, max 76799.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [X_W-1:0] x,
                                                   input logic [Y_W-1:0] y);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 8) + (yw << 6) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/plot_receiver_if.sv
// Client-side bus of the plot receiver: pixel write requests, pixel readback
// and status. The framebuffer RAM port stays on the module itself.
interface plot_receiver_if;
    import plot_receiver_pkg::*;

    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [COLOUR_W-1:0] colour;
    logic                plot;
    logic                plot_ready;

    logic                rd_req;
    logic [X_W-1:0]      rd_x;
    logic [Y_W-1:0]      rd_y;
    logic                rd_busy;
    logic                rd_valid;
    logic [COLOUR_W-1:0] rd_data;

    logic [CLIP_W-1:0]   clip_cnt;
    logic                overflow;

    // Drawing client side.
    modport master (
        output x, y, colour, plot, rd_req, rd_x, rd_y,
        input  plot_ready, rd_busy, rd_valid, rd_data, clip_cnt, overflow
    );

    // Receiver side.
    modport slave (
        input  x, y, colour, plot, rd_req, rd_x, rd_y,
        output plot_ready, rd_busy, rd_valid, rd_data, clip_cnt, overflow
    );

endinterface

// File: rtl/plot_fifo.sv
// Synchronous FIFO buffering pixel writes between the client and the
// framebuffer FSM. A push while full succeeds only with a simultaneous pop.
// The empty flag is registered: a newly written entry becomes visible to the
// reader one cycle after the write, and emptiness is flagged immediately.
module plot_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 29
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             empty_q, empty_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = empty_q;
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && (count_q != '0);
    assign rd_data = mem_q[rd_ptr_q];

    // Next pointer, occupancy and empty-flag values.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
        empty_d = (count_q == '0) || (count_d == '0);
    end

    // Pointer and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers and count define which entries are valid.
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/plot_receiver.sv
// Pixel plot receiver: clips and buffers pixel writes, then drains them into a
// framebuffer RAM one pixel per two cycles, with priority pixel readback.
module plot_receiver
    import plot_receiver_pkg::*;
#(
    parameter int SCREEN_W   = DEF_SCREEN_W,
    parameter int SCREEN_H   = DEF_SCREEN_H,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    plot_receiver_if.slave      pif,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOUR_W-1:0] fb_data,
    output logic                fb_we,
    input  logic [COLOUR_W-1:0] fb_q
);

    localparam logic [X_W:0] X_LIM = SCREEN_W[X_W:0];
    localparam logic [Y_W:0] Y_LIM = SCREEN_H[Y_W:0];

    state_e              state_q;
    logic [ADDR_W-1:0]   fb_addr_q;
    logic [COLOUR_W-1:0] fb_data_q;
    logic                fb_we_q;
    logic                rd_busy_q;
    logic                rd_valid_q;
    logic [COLOUR_W-1:0] rd_data_q;
    logic [CLIP_W-1:0]   clip_cnt_q, clip_cnt_d;
    logic                overflow_q, overflow_d;

    logic   plot_on, rd_on;
    logic   fifo_full, fifo_empty, push, pop;
    entry_t push_entry, head;

    function automatic logic on_screen(input logic [X_W-1:0] px, input logic [Y_W-1:0] py);
        return ({1'b0, px} < X_LIM) && ({1'b0, py} < Y_LIM);
    endfunction

    assign plot_on    = on_screen(pif.x, pif.y);
    assign rd_on      = on_screen(pif.rd_x, pif.rd_y);
    // plot_ready reflects occupancy before any same-cycle pop.
    assign push       = pif.plot && plot_on && !fifo_full;
    assign pop        = (state_q == ST_WRITE);
    assign push_entry = '{addr: pix_addr(pif.x, pif.y), colour: pif.colour};

    plot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_fifo (
        .clk     (CLOCK_50),
        .rst_n   (resetn),
        .push    (push),
        .pop     (pop),
        .wr_data (push_entry),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Off-screen plots bump the saturating clip counter; on-screen plots into a full buffer set the sticky overflow.
    always_comb begin
        clip_cnt_d = clip_cnt_q;
        overflow_d = overflow_q;
        if (pif.plot && !plot_on && (clip_cnt_q != '1)) clip_cnt_d = clip_cnt_q + CLIP_W'(1);
        if (pif.plot && plot_on && fifo_full)           overflow_d = 1'b1;
    end

    // Status counter registers.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            clip_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            clip_cnt_q <= clip_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Framebuffer access FSM with registered RAM-port and readback outputs; reads win over pending writes.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
            fb_we_q    <= 1'b0;
            rd_busy_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            fb_we_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pif.rd_req) begin
                        if (rd_on) begin
                            state_q   <= ST_RD_ADDR;
                            fb_addr_q <= pix_addr(pif.rd_x, pif.rd_y);
                            rd_busy_q <= 1'b1;
                        end else begin
                            // Off-screen readback answers immediately without touching the RAM.
                            rd_data_q  <= '0;
                            rd_valid_q <= 1'b1;
                        end
                    end else if (!fifo_empty) begin
                        state_q   <= ST_WRITE;
                        fb_addr_q <= head.addr;
                        fb_data_q <= head.colour;
                        fb_we_q   <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_q <= ST_IDLE;
                end
                ST_RD_ADDR: begin
                    state_q <= ST_RD_WAIT;
                end
                ST_RD_WAIT: begin
                    state_q    <= ST_IDLE;
                    rd_data_q  <= fb_q;
                    rd_valid_q <= 1'b1;
                    rd_busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign fb_addr      = fb_addr_q;
    assign fb_data      = fb_data_q;
    assign fb_we        = fb_we_q;
    assign pif.plot_ready = !fifo_full;
    assign pif.rd_busy  = rd_busy_q;
    assign pif.rd_valid = rd_valid_q;
    assign pif.rd_data  = rd_data_q;
    assign pif.clip_cnt = clip_cnt_q;
    assign pif.overflow = overflow_q;

endmodule
